// File: rtl/timer_pkg.sv
// Shared definitions for the clock-timer command sequencer.
// Holds ROM command codes, timer and fetch state encodings, and the MM:SS limits.
package timer_pkg;

  localparam int unsigned CMD_IDLE  = 0;
  localparam int unsigned CMD_START = 1;
  localparam int unsigned CMD_PAUSE = 2;
  localparam int unsigned CMD_STOP  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_STOP  = 2'd3
  } tstate_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_CAP  = 2'd2
  } fstate_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/timer_mmss.sv
// MM:SS time base: tick prescaler plus seconds/minutes counters.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   run         advance the prescaler this cycle
//   clear       synchronously zero prescaler, sec, min (wins over run)
//   sec, min    current time, 0..59 each
//   ovf         one-cycle pulse when 59:59 rolls over to 00:00
module timer_mmss
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clear,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       ovf
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      presc <= '0;
      sec   <= '0;
      min   <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (run) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          if (sec == SEC_MAX) begin
            sec <= '0;
            if (min == MIN_MAX) begin
              min <= '0;
              ovf <= 1'b1;
            end else begin
              min <= min + 6'd1;
            end
          end else begin
            sec <= sec + 6'd1;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/timer_cmd_sequencer.sv
// Clock-timer command sequencer: fetches commands from an external registered
// ROM on each step request and applies them to the IDLE/RUN/PAUSE/STOP timer FSM.
// Optional build macro: TIMER_AUTO_STEP_EN adds an internal step generator
// firing every STEP_DIV cycles while the timer is not stopped.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   step        one-cycle fetch request
//   rom_valid   ROM read strobe (one cycle per fetch), rom_addr ROM address
//   rom_data    registered ROM output, valid the cycle after rom_valid
//   state       timer state (0 IDLE, 1 RUN, 2 PAUSE, 3 STOP)
//   sec, min    MM:SS time
//   busy        fetch in progress
//   wrap        pulse when rom_addr wraps to 0
//   ovf         pulse when 59:59 rolls to 00:00
//   cmd_err     pulse when an illegal command code is captured
module timer_cmd_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 3,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned STEP_DIV  = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step,
  output logic                 rom_valid,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [DATA_SIZE-1:0] rom_data,
  output logic [1:0]           state,
  output logic [5:0]           sec,
  output logic [5:0]           min,
  output logic                 busy,
  output logic                 wrap,
  output logic                 ovf,
  output logic                 cmd_err
);

  if (TICK_DIV < 2 || STEP_DIV < 1) begin : g_bad_param
    $error("timer_cmd_sequencer: TICK_DIV must be >= 2 and STEP_DIV >= 1");
  end

  fstate_e fstate, fstate_nxt;
  tstate_e tstate, tstate_nxt;
  logic    pending, pending_nxt;
  logic    step_in, auto_step;
  logic    clear, run, bad_cmd;

`ifdef TIMER_AUTO_STEP_EN
  localparam int unsigned SW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  logic [SW-1:0] step_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt  <= '0;
      auto_step <= 1'b0;
    end else if (tstate != ST_STOP) begin
      if (step_cnt == SW'(STEP_DIV - 1)) begin
        step_cnt  <= '0;
        auto_step <= 1'b1;
      end else begin
        step_cnt  <= step_cnt + SW'(1);
        auto_step <= 1'b0;
      end
    end else begin
      auto_step <= 1'b0;
    end
  end
`else
  assign auto_step = 1'b0;
`endif

  assign step_in = step | auto_step;

  always_comb begin
    fstate_nxt  = fstate;
    pending_nxt = pending;
    case (fstate)
      F_IDLE: begin
        // A pending request is consumed here; a coincident step is dropped.
        if (step_in || pending) begin
          fstate_nxt  = F_REQ;
          pending_nxt = 1'b0;
        end
      end
      F_REQ: begin
        fstate_nxt = F_CAP;
        if (step_in) pending_nxt = 1'b1;
      end
      F_CAP: begin
        fstate_nxt = F_IDLE;
        if (step_in) pending_nxt = 1'b1;
      end
      default: fstate_nxt = F_IDLE;
    endcase
  end

  always_comb begin
    tstate_nxt = tstate;
    clear      = 1'b0;
    bad_cmd    = 1'b0;
    if (fstate == F_CAP) begin
      case (rom_data)
        DATA_SIZE'(CMD_IDLE): begin
          tstate_nxt = ST_IDLE;
          clear      = 1'b1;
        end
        DATA_SIZE'(CMD_START): if (tstate != ST_STOP) tstate_nxt = ST_RUN;
        DATA_SIZE'(CMD_PAUSE): if (tstate == ST_RUN) tstate_nxt = ST_PAUSE;
        DATA_SIZE'(CMD_STOP):  if (tstate != ST_IDLE) tstate_nxt = ST_STOP;
        default: bad_cmd = 1'b1;
      endcase
    end
  end

  // Counting requires RUN both now and next: a command leaving RUN discards
  // a coincident tick, leaving the prescaler held at its last value.
  assign run = (tstate == ST_RUN) && (tstate_nxt == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fstate   <= F_IDLE;
      tstate   <= ST_IDLE;
      pending  <= 1'b0;
      rom_addr <= '0;
      wrap     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      fstate  <= fstate_nxt;
      tstate  <= tstate_nxt;
      pending <= pending_nxt;
      wrap    <= (fstate == F_CAP) && (rom_addr == '1);
      cmd_err <= bad_cmd;
      if (fstate == F_CAP) rom_addr <= rom_addr + ADDR_SIZE'(1);
    end
  end

  assign rom_valid = (fstate == F_REQ);
  assign busy      = (fstate != F_IDLE);
  assign state     = tstate;

  timer_mmss #(.TICK_DIV(TICK_DIV)) u_mmss (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clear (clear),
    .sec   (sec),
    .min   (min),
    .ovf   (ovf)
  );

endmodule
